// File: rtl/mem_pkg.sv
// Shared types and constants for the 6502 SRAM controller.
// Build option: SRAM_CTRL_SYNC_IN_EN registers the SRAM read data before delivery.
package mem_pkg;

   localparam int unsigned ADDR_W      = 24;
   localparam int unsigned DATA_W      = 8;
   localparam int unsigned WAIT_W      = 4;
   localparam int unsigned BURST_LEN   = 8;
   localparam int unsigned BURST_OFF_W = 3;

`ifdef SRAM_CTRL_SYNC_IN_EN
   localparam bit SYNC_IN_EN = 1'b1;
`else
   localparam bit SYNC_IN_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      RECOV
   } Sram_State_Type;

   // Registered drive towards the external SRAM pins.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              ce_n;
      logic              oe_n;
      logic              we_n;
      logic              dq_oe;
      logic [DATA_W-1:0] dq_o;
   } sram_drv_t;

   // Next address of a fill burst: line offset wraps, line base is held.
   function automatic logic [ADDR_W-1:0] burst_next_addr(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:BURST_OFF_W], BURST_OFF_W'(a[BURST_OFF_W-1:0] + 1'b1)};
   endfunction

endpackage

// File: rtl/sram_ctrl_6502_if.sv
// Cache-side memory port of the SRAM controller.
interface sram_ctrl_6502_if;

   logic [mem_pkg::ADDR_W-1:0] mem_addr;
   logic                       mem_en;
   logic                       mem_wr;
   logic                       mem_rburst;
   logic                       mem_wburst;
   logic [mem_pkg::DATA_W-1:0] mem_wdata;
   logic                       mem_rdy;
   logic [mem_pkg::DATA_W-1:0] mem_rdata;
   logic [mem_pkg::DATA_W-1:0] mem_rdata0;
   logic                       mem_rdata_load;

   modport master (
      output mem_addr, mem_en, mem_wr, mem_rburst, mem_wburst, mem_wdata,
      input  mem_rdy, mem_rdata, mem_rdata0, mem_rdata_load
   );

   modport slave (
      input  mem_addr, mem_en, mem_wr, mem_rburst, mem_wburst, mem_wdata,
      output mem_rdy, mem_rdata, mem_rdata0, mem_rdata_load
   );

endinterface

// File: rtl/sram_ctrl_6502_sram_dq_sync.sv
// Delivery path for completed beats: direct from the SRAM pins, or, with
// SRAM_CTRL_SYNC_IN_EN defined, through a capture register with the read
// strobe delayed by one cycle. Write beats are never delayed.
module sram_dq_sync
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_rd,
   input  logic              ld_wr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] dq_i,
   output logic              load_c,
   output logic [DATA_W-1:0] data0_c
);

`ifdef SRAM_CTRL_SYNC_IN_EN
   logic [DATA_W-1:0] cap_q;
   logic              dly_q;

   // Capture read data on the beat's last cycle and delay its strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_q <= '0;
         dly_q <= 1'b0;
      end else begin
         dly_q <= ld_rd;
         if (ld_rd) begin
            cap_q <= dq_i;
         end
      end
   end

   assign load_c  = dly_q | ld_wr;
   assign data0_c = ld_wr ? wdata : cap_q;
`else
   logic unused_clk_rst;

   assign unused_clk_rst = clk ^ rst;
   assign load_c         = ld_rd | ld_wr;
   assign data0_c        = ld_wr ? wdata : dq_i;
`endif

endmodule

// File: rtl/sram_ctrl_6502.sv
// SRAM controller behind the 6502 cache: single byte reads/writes and
// 8-byte wrapping fill bursts on an asynchronous byte-wide SRAM.
// Build option: SRAM_CTRL_SYNC_IN_EN (registered read data, one extra cycle).
module sram_ctrl_6502
   import mem_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst,
   sram_ctrl_6502_if.slave   bus,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [DATA_W-1:0] sram_dq_o,
   output logic              sram_dq_oe,
   input  logic [DATA_W-1:0] sram_dq_i
);

   localparam logic [WAIT_W-1:0]      WAIT_CNT  = WAIT_W'(WAIT_STATES);
   localparam logic [BURST_OFF_W-1:0] LAST_BEAT = BURST_OFF_W'(BURST_LEN - 1);
   localparam bit                     NO_WAIT   = (WAIT_STATES == 0);

   Sram_State_Type         state_q, state_d;
   logic [WAIT_W-1:0]      cnt_q, cnt_d;
   logic [BURST_OFF_W-1:0] beat_q, beat_d;
   logic                   burst_q, burst_d;
   logic                   ext_q, ext_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   sram_drv_t              drv_q, drv_d;
   logic                   rdy_q, rdy_d;
   logic                   ld_rd_q, ld_rd_d;
   logic                   ld_wr_q, ld_wr_d;
   logic [DATA_W-1:0]      rdata_q;
   logic                   load_c;
   logic [DATA_W-1:0]      data0_c;
   logic                   unused_wburst;

   assign unused_wburst = bus.mem_wburst;

   // Next state, beat sequencing and SRAM strobe generation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      beat_d  = beat_q;
      burst_d = burst_q;
      ext_d   = ext_q;
      wdata_d = wdata_q;
      drv_d   = drv_q;
      rdy_d   = rdy_q;
      ld_rd_d = 1'b0;
      ld_wr_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.mem_en) begin
               drv_d.addr = bus.mem_addr;
               drv_d.ce_n = 1'b0;
               cnt_d      = WAIT_CNT;
               beat_d     = '0;
               burst_d    = bus.mem_rburst & ~bus.mem_wr;
               wdata_d    = bus.mem_wdata;
               ext_d      = 1'b0;
               rdy_d      = 1'b0;
               if (bus.mem_wr) begin
                  state_d     = WRITE;
                  drv_d.we_n  = 1'b0;
                  drv_d.dq_oe = 1'b1;
                  drv_d.dq_o  = bus.mem_wdata;
                  ld_wr_d     = NO_WAIT;
               end else begin
                  state_d    = READ;
                  drv_d.oe_n = 1'b0;
                  ld_rd_d    = NO_WAIT;
               end
            end
         end
         READ: begin
            if (cnt_q != '0) begin
               cnt_d   = cnt_q - 1'b1;
               ld_rd_d = (cnt_q == WAIT_W'(1));
            end else if (burst_q && (beat_q != LAST_BEAT)) begin
               beat_d     = beat_q + 1'b1;
               cnt_d      = WAIT_CNT;
               drv_d.addr = burst_next_addr(drv_q.addr);
               ld_rd_d    = NO_WAIT;
            end else begin
               state_d    = RECOV;
               drv_d.ce_n = 1'b1;
               drv_d.oe_n = 1'b1;
               ext_d      = SYNC_IN_EN;
            end
         end
         WRITE: begin
            if (cnt_q != '0) begin
               cnt_d   = cnt_q - 1'b1;
               ld_wr_d = (cnt_q == WAIT_W'(1));
            end else begin
               state_d    = RECOV;
               drv_d.ce_n = 1'b1;
               drv_d.we_n = 1'b1;
            end
         end
         RECOV: begin
            // Extra recovery cycle covers the delayed final read strobe.
            if (ext_q) begin
               ext_d = 1'b0;
            end else begin
               state_d     = IDLE;
               drv_d.dq_oe = 1'b0;
               rdy_d       = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         beat_q     <= '0;
         burst_q    <= 1'b0;
         ext_q      <= 1'b0;
         wdata_q    <= '0;
         drv_q.addr <= '0;
         drv_q.ce_n <= 1'b1;
         drv_q.oe_n <= 1'b1;
         drv_q.we_n <= 1'b1;
         drv_q.dq_oe <= 1'b0;
         drv_q.dq_o <= '0;
         rdy_q      <= 1'b1;
         ld_rd_q    <= 1'b0;
         ld_wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         beat_q  <= beat_d;
         burst_q <= burst_d;
         ext_q   <= ext_d;
         wdata_q <= wdata_d;
         drv_q   <= drv_d;
         rdy_q   <= rdy_d;
         ld_rd_q <= ld_rd_d;
         ld_wr_q <= ld_wr_d;
      end
   end

   sram_dq_sync u_dq_sync (
      .clk     (clk),
      .rst     (rst),
      .ld_rd   (ld_rd_q),
      .ld_wr   (ld_wr_q),
      .wdata   (wdata_q),
      .dq_i    (sram_dq_i),
      .load_c  (load_c),
      .data0_c (data0_c)
   );

   // Copy of the last delivered byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (load_c) begin
         rdata_q <= data0_c;
      end
   end

   assign bus.mem_rdy        = rdy_q;
   assign bus.mem_rdata      = rdata_q;
   assign bus.mem_rdata0     = data0_c;
   assign bus.mem_rdata_load = load_c;
   assign sram_addr          = drv_q.addr;
   assign sram_ce_n          = drv_q.ce_n;
   assign sram_oe_n          = drv_q.oe_n;
   assign sram_we_n          = drv_q.we_n;
   assign sram_dq_oe         = drv_q.dq_oe;
   assign sram_dq_o          = drv_q.dq_o;

endmodule

// File: tb/tb_sram_ctrl_6502.sv
// Bench for sram_ctrl_6502: transaction-level model plus directed literals.
// Honours SRAM_CTRL_SYNC_IN_EN for the read delivery lag.
module tb_sram_ctrl_6502;

   localparam int unsigned W = 2;
   localparam int          P = W + 1;
`ifdef SRAM_CTRL_SYNC_IN_EN
   localparam int          LAG = 1;
`else
   localparam int          LAG = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] sram_addr;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;
   logic [7:0]  sram_dq_o, sram_dq_i;

   sram_ctrl_6502_if bus();

   sram_ctrl_6502 #(.WAIT_STATES(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sram_addr  (sram_addr),
      .sram_ce_n  (sram_ce_n),
      .sram_oe_n  (sram_oe_n),
      .sram_we_n  (sram_we_n),
      .sram_dq_o  (sram_dq_o),
      .sram_dq_oe (sram_dq_oe),
      .sram_dq_i  (sram_dq_i)
   );

   always #5 clk = ~clk;

   // SRAM contents as a fixed function of the address.
   function automatic logic [7:0] sram_f(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h83;
   endfunction

   assign sram_dq_i = sram_f(sram_addr);

   int cyc      = 0;
   int n_checks = 0;
   int n_err    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Transaction in flight, as seen by the model.
   bit          m_active = 1'b0;
   int          m_t0     = 0;
   logic [23:0] m_addr   = '0;
   bit          m_wr     = 1'b0;
   bit          m_burst  = 1'b0;
   logic [7:0]  m_wdata  = '0;
   logic [7:0]  m_last   = '0;

   function automatic int m_beats();
      return (m_burst && !m_wr) ? 8 : 1;
   endfunction

   function automatic int m_lag();
      return m_wr ? 0 : LAG;
   endfunction

   function automatic int m_dur();
      return m_beats() * P + 2 + m_lag();
   endfunction

   function automatic logic [23:0] beat_addr(input int k);
      return {m_addr[23:3], 3'(int'(m_addr[2:0]) + k)};
   endfunction

   function automatic bit m_idle(input int c);
      return !m_active || (c - m_t0 >= m_dur());
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Compare every output against the model once per cycle.
   always @(negedge clk) begin : cmp
      logic        e_rdy, e_load, e_ce, e_oe, e_we, e_dqoe, c_addr;
      logic [7:0]  e_d0;
      logic [23:0] e_addr;
      int          d, dl;
      if (rst) begin
         chk("rst_rdy", bus.mem_rdy, 1);
         chk("rst_load", bus.mem_rdata_load, 0);
         chk("rst_rdata", bus.mem_rdata, 0);
         chk("rst_ce_n", sram_ce_n, 1);
         chk("rst_oe_n", sram_oe_n, 1);
         chk("rst_we_n", sram_we_n, 1);
         chk("rst_dq_oe", sram_dq_oe, 0);
         chk("rst_addr", sram_addr, 0);
         chk("rst_dq_o", sram_dq_o, 0);
         m_last = '0;
      end else begin
         e_rdy = 1'b1; e_load = 1'b0; e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1;
         e_dqoe = 1'b0; c_addr = 1'b0; e_d0 = '0; e_addr = '0;
         d = cyc - m_t0;
         if (m_active && d >= 1 && d < m_dur()) begin
            e_rdy = 1'b0;
            if (d <= m_beats() * P) begin
               e_ce   = 1'b0;
               e_oe   = m_wr;
               e_we   = !m_wr;
               e_dqoe = m_wr;
               e_addr = beat_addr((d - 1) / P);
               c_addr = 1'b1;
            end else begin
               e_dqoe = m_wr;
               e_addr = m_addr;
               c_addr = m_wr;
            end
            dl = d - m_lag();
            if (dl >= P && dl <= m_beats() * P && (dl % P) == 0) begin
               e_load = 1'b1;
               e_d0   = m_wr ? m_wdata : sram_f(beat_addr(dl / P - 1));
            end
         end
         chk("rdy", bus.mem_rdy, e_rdy);
         chk("load", bus.mem_rdata_load, e_load);
         chk("rdata", bus.mem_rdata, m_last);
         chk("ce_n", sram_ce_n, e_ce);
         chk("oe_n", sram_oe_n, e_oe);
         chk("we_n", sram_we_n, e_we);
         chk("dq_oe", sram_dq_oe, e_dqoe);
         if (e_load) chk("rdata0", bus.mem_rdata0, e_d0);
         if (e_dqoe) chk("dq_o", sram_dq_o, m_wdata);
         if (c_addr) chk("addr", sram_addr, e_addr);
         if (e_load) m_last = e_d0;
      end
   end

   // Advance one cycle; while busy the cache side is free to wiggle.
   task automatic step();
      @(posedge clk);
      #1;
      if (m_idle(cyc)) begin
         bus.mem_en = 1'b0;
      end else begin
         bus.mem_en     = 1'($urandom_range(0, 1));
         bus.mem_addr   = 24'($urandom);
         bus.mem_wr     = 1'($urandom_range(0, 1));
         bus.mem_rburst = 1'($urandom_range(0, 1));
         bus.mem_wburst = 1'($urandom_range(0, 1));
         bus.mem_wdata  = 8'($urandom);
      end
   endtask

   task automatic issue(input logic [23:0] a, input bit wr, input bit rb, input bit wb,
                        input logic [7:0] wd);
      while (!m_idle(cyc)) step();
      bus.mem_en     = 1'b1;
      bus.mem_addr   = a;
      bus.mem_wr     = wr;
      bus.mem_rburst = rb;
      bus.mem_wburst = wb;
      bus.mem_wdata  = wd;
      m_active = 1'b1;
      m_t0     = cyc;
      m_addr   = a;
      m_wr     = wr;
      m_burst  = rb;
      m_wdata  = wd;
      step();
   endtask

   task automatic walk_to(input int d);
      while (cyc < m_t0 + d) step();
   endtask

   logic [23:0] bst_exp [8] = '{24'h00F3FA, 24'h00F3FB, 24'h00F3FC, 24'h00F3FD,
                                24'h00F3FE, 24'h00F3FF, 24'h00F3F8, 24'h00F3F9};

   initial begin
      bus.mem_en = 1'b0; bus.mem_addr = '0; bus.mem_wr = 1'b0;
      bus.mem_rburst = 1'b0; bus.mem_wburst = 1'b0; bus.mem_wdata = '0;
      #1 rst = 1'b1;
      step(); step(); step();
      rst = 1'b0;
      step();

      // single read
      issue(24'h001234, 1'b0, 1'b0, 1'b0, 8'h00);
      walk_to(1); #3;
      chk("rd_addr_t1", sram_addr, 24'h001234);
      chk("rd_oe_t1", sram_oe_n, 0);
      walk_to(3 + LAG); #3;
      chk("rd_load_lit", bus.mem_rdata_load, 1);
      chk("rd_data0_lit", bus.mem_rdata0, 8'hA5);
      walk_to(4 + LAG); #3;
      chk("rd_rdata_lit", bus.mem_rdata, 8'hA5);
      chk("rd_rdy_recov", bus.mem_rdy, 0);
      walk_to(5 + LAG); #3;
      chk("rd_rdy_idle", bus.mem_rdy, 1);

      // wrapping fill burst
      issue(24'h00F3FA, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int k = 0; k < 8; k++) begin
         walk_to(1 + k * P); #3;
         chk("bst_addr_lit", sram_addr, bst_exp[k]);
         chk("bst_ce_lit", sram_ce_n, 0);
      end
      walk_to(8 * P + LAG); #3;
      chk("bst_last_load", bus.mem_rdata_load, 1);
      chk("bst_last_data", bus.mem_rdata0, 8'h89);
      walk_to(8 * P + 2 + LAG); #3;
      chk("bst_rdy_lit", bus.mem_rdy, 1);

      // single write
      issue(24'h000200, 1'b1, 1'b0, 1'b0, 8'h5A);
      walk_to(1); #3;
      chk("wr_we_t1", sram_we_n, 0);
      chk("wr_oe_t1", sram_dq_oe, 1);
      chk("wr_dq_t1", sram_dq_o, 8'h5A);
      walk_to(3); #3;
      chk("wr_load_lit", bus.mem_rdata_load, 1);
      chk("wr_data0_lit", bus.mem_rdata0, 8'h5A);
      walk_to(4); #3;
      chk("wr_recov_we", sram_we_n, 1);
      chk("wr_recov_dqoe", sram_dq_oe, 1);
      chk("wr_recov_addr", sram_addr, 24'h000200);
      walk_to(5); #3;
      chk("wr_idle_dqoe", sram_dq_oe, 0);
      chk("wr_idle_rdy", bus.mem_rdy, 1);

      // write with burst flags set stays a single write
      issue(24'h000300, 1'b1, 1'b1, 1'b1, 8'hC3);
      walk_to(5); #3;
      chk("wrb_rdy_lit", bus.mem_rdy, 1);

      // reset in the middle of beat 4
      issue(24'h000010, 1'b0, 1'b1, 1'b0, 8'h00);
      walk_to(1 + 4 * P + 1); #2;
      rst = 1'b1;
      m_active = 1'b0;
      m_last = '0;
      #1;
      chk("mid_rst_ce", sram_ce_n, 1);
      chk("mid_rst_oe", sram_oe_n, 1);
      chk("mid_rst_rdy", bus.mem_rdy, 1);
      step(); step();
      rst = 1'b0;
      repeat (3 * P) step();
      issue(24'h0055AA, 1'b0, 1'b0, 1'b0, 8'h00);
      walk_to(3 + LAG); #3;
      chk("post_rst_load", bus.mem_rdata_load, 1);
      chk("post_rst_data", bus.mem_rdata0, 8'h7C);

      // random traffic, including back-to-back requests
      for (int i = 0; i < 60; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         repeat (gap) step();
         issue(24'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom));
      end
      while (!m_idle(cyc)) step();
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cycle %0d got no finish expected finish", cyc);
      $fatal(1);
   end

endmodule

// File: doc/sram_ctrl_6502.md
# sram_ctrl_6502

Memory-side controller directly downstream of the 6502 cache: accepts single-byte reads/writes and fixed 8-byte instruction-fill read bursts on the cache's `mem_*` port. Drives an external asynchronous byte-wide SRAM with a programmable wait-state count. Returns each byte with a one-cycle `mem_rdata_load` strobe that the cache latches in the same cycle.

## Interface
- `WAIT_STATES`, 2, extra cycles per SRAM access; each beat lasts `WAIT_STATES+1` cycles, legal range 0..15.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_addr`  in  24  byte address; sampled only at accept.
- `mem_en`  in  1  request; sampled only in IDLE.
- `mem_wr`  in  1  write request; sampled at accept.
- `mem_rburst`  in  1  8-byte read burst; sampled at accept.
- `mem_wburst`  in  1  unsupported; ignored.
- `mem_wdata`  in  8  write byte; sampled at accept.
- `mem_rdy`  out  1  high only in IDLE (can accept).
- `mem_rdata`  out  8  registered copy of the last delivered byte.
- `mem_rdata0`  out  8  byte being delivered; valid only while `mem_rdata_load` is high.
- `mem_rdata_load`  out  1  one-cycle strobe per completed beat, reads and writes.
- `sram_addr`  out  24  SRAM address.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  active-low strobes.
- `sram_dq_o`  out  8  write data.
- `sram_dq_oe`  out  1  data bus drive enable.
- `sram_dq_i`  in  8  read data.

## Operation
- **States:**
  - IDLE: on `mem_en=1`, latch addr, wr, wdata and burst. Go to READ if `!mem_wr`, else WRITE.
  - READ: run beats. After the last beat, go to RECOV.
  - WRITE: run one beat, then go to RECOV.
  - RECOV: one cycle, then IDLE.
- **Beat length:** read burst = 8 beats; single read = 1 beat. `mem_wr` together with `mem_rburst` is treated as a single write.
- **After accept:** `mem_en`, `mem_addr` and `mem_rburst` are ignored. The cache drops `mem_en` during its last fill byte and changes `mem_addr`, but the burst still completes all 8 beats.
- **Burst addressing:** `addr[2:0]` increments mod 8 per beat; `addr[23:3]` is held. The start offset is whatever was latched, giving wrap-around within the 8-byte line.
- **Read beat:**
  - `sram_ce_n=0` and `sram_oe_n=0` for the whole burst, with no deassert between beats.
  - Wait counter counts `WAIT_STATES` down to 0.
  - On the last cycle of the beat, `sram_dq_i` is sampled.
- **Write beat:**
  - `sram_ce_n=0`, `sram_we_n=0`, `sram_dq_oe=1`, `sram_dq_o`=latched wdata.
  - On the last cycle, `mem_rdata_load=1` and `mem_rdata0`=latched wdata.
- **RECOV:** `ce_n`, `oe_n` and `we_n` are 1. For writes, `sram_dq_oe` stays 1 and `sram_addr` is held (data hold); `sram_dq_oe=0` on entry to IDLE.
- **Reset values:** `mem_rdy=1`, `mem_rdata_load=0`, `mem_rdata=0`, `sram_ce_n/oe_n/we_n=1`, `sram_dq_oe=0`, `sram_addr=0`, `sram_dq_o=0`.
- **Reset mid-transaction:** state goes to IDLE asynchronously. All strobes deassert immediately and no further loads occur.

## Timing
- The request is accepted in cycle T0. The first access cycle is T1.
- **Single read:**
  - `mem_rdata_load` at T0+1+W (W=`WAIT_STATES`), with `mem_rdata0=sram_dq_i` combinationally.
  - `mem_rdata` updates at T0+2+W.
  - RECOV is T0+2+W; `mem_rdy=1` at T0+3+W.
- **Burst:** beat k (0..7) loads at T0+1+W+k·(W+1). RECOV follows the 8th load.
- **Write:** `sram_we_n` low T1..T1+W, load at T1+W, RECOV at T1+W+1.
- **Back-to-back:** a new request can be accepted on the first cycle `mem_rdy=1`. Throughput for a single access is W+3 cycles.

## Configuration
- `SRAM_CTRL_SYNC_IN_EN` defined:
  - `sram_dq_i` is captured into a register on the beat's last cycle.
  - `mem_rdata_load` and `mem_rdata0` (now sourced from that register) are delayed by exactly one cycle.
  - The next beat's SRAM access proceeds unchanged (pipelined).
  - RECOV waits for the final delayed load; `mem_rdy` is one cycle later than without the macro.
  - Write timing is unchanged.
- Undefined: combinational path from `sram_dq_i` to `mem_rdata0`, with timing as above.

## Structure
- Shared package `mem_pkg`:
  - `Sram_State_Type` enum (IDLE, READ, WRITE, RECOV).
  - `BURST_LEN=8` constant.
  - `BURST_OFF_W=3` constant.
- One sub-module, `sram_dq_sync`: the optional input capture register plus load-strobe delay, selected by `SRAM_CTRL_SYNC_IN_EN`.

## Test plan
- **Single read,** W=2, addr 0x001234, `sram_dq_i=0xA5` → `sram_addr=0x001234` T1..T3; load at T0+3 with `mem_rdata0=0xA5`; `mem_rdata=0xA5` at T0+4; `mem_rdy=1` at T0+5.
- **Burst,** W=2, addr 0x00F3FA → 8 loads at T0+3, +6, …, +24; `sram_addr` goes FA,FB,FC,FD,FE,FF,F8,F9 with upper bits 0x00F3; `ce_n` stays low throughout.
- **Write,** W=2, 0x5A to 0x000200 → `we_n` low T0+1..T0+3; load at T0+3; `dq_oe=1` T0+1..T0+4; `dq_oe=0` at T0+5.
- **Burst with `mem_en` dropped and `mem_addr` changed after beat 6** → all 8 beats still issue, with the original addresses.
- **`rst` asserted during beat 4 of a burst** → same-cycle `ce_n/oe_n=1`; no further loads; `mem_rdy=1`; the next request completes normally.
- **`SRAM_CTRL_SYNC_IN_EN`,** W=0, burst → loads at T0+2..T0+9, each carrying the byte sampled one cycle earlier.
